// File: rtl/proto_pkg.sv
// Shared types and constants for the protocolo_tx serial frame transmitter.
package proto_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_GUARD = 2'd3
   } state_t;

   localparam int                   DATA_BITS = 4;
   localparam int                   CNT_W     = 8;
   localparam logic [DATA_BITS-1:0] CODE_ON   = 4'b1001;
   localparam logic [DATA_BITS-1:0] CODE_OFF  = 4'b1010;

   // Line level for a given FSM position: high when idle/guard, low for start.
   function automatic logic frame_bit(input state_t st, input logic [1:0] idx,
                                      input logic [DATA_BITS-1:0] code);
      logic lvl;
      case (st)
         ST_IDLE:  lvl = 1'b1;
         ST_START: lvl = 1'b0;
         ST_DATA:  lvl = code[idx];
         ST_GUARD: lvl = 1'b1;
         default:  lvl = 1'b1;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/proto_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled, strobes bit_end on
// the last cycle and also reports whether the following cycle will be a last one.
module proto_bit_timer import proto_pkg::*; #(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bit_end,
   output logic bit_end_nx
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;

   // Next count: held at zero while idle, wraps on every bit boundary.
   always_comb begin
      cnt_nx_s = 8'd0;
      if (!en || (cnt_r == LAST)) begin
         cnt_nx_s = 8'd0;
      end else begin
         cnt_nx_s = cnt_r + 8'd1;
      end
   end

   assign bit_end    = en && (cnt_r == LAST);
   assign bit_end_nx = (cnt_nx_s == LAST);

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

endmodule

// File: rtl/protocolo_tx.sv
// Serial frame transmitter: start 0, four code bits LSB first, guard 1.
// Optional one-deep request queue while busy enabled by macro PROTO_TX_PEND_EN.
module protocolo_tx import proto_pkg::*; #(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_on,
   input  logic key_off,
   output logic data,
   output logic busy,
   output logic done
);

   state_t                 state_r, state_nx_s;
   logic [1:0]             idx_r, idx_nx_s;
   logic [DATA_BITS-1:0]   code_r, code_nx_s;
   logic                   req_valid_s;
   logic [DATA_BITS-1:0]   req_code_s;
   logic                   timer_en_s, bit_end_s, bit_end_nx_s;
   logic                   data_nx_s, busy_nx_s, done_nx_s;
   logic                   data_r, busy_r, done_r;

   assign req_valid_s = key_on ^ key_off;
   assign req_code_s  = key_on ? CODE_ON : CODE_OFF;
   assign timer_en_s  = (state_r != ST_IDLE);

   proto_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .en         (timer_en_s),
      .bit_end    (bit_end_s),
      .bit_end_nx (bit_end_nx_s)
   );

`ifdef PROTO_TX_PEND_EN
   logic                 pend_valid_r, pend_valid_nx_s;
   logic [DATA_BITS-1:0] pend_code_r, pend_code_nx_s;

   // Pending slot: first valid request while busy, released at the end of guard.
   always_comb begin
      pend_valid_nx_s = pend_valid_r;
      pend_code_nx_s  = pend_code_r;
      if ((state_r == ST_GUARD) && bit_end_s) begin
         pend_valid_nx_s = 1'b0;
      end else if (timer_en_s && req_valid_s && !pend_valid_r) begin
         pend_valid_nx_s = 1'b1;
         pend_code_nx_s  = req_code_s;
      end else begin
         pend_valid_nx_s = pend_valid_r;
      end
   end

   // Pending slot register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
         pend_code_r  <= 4'd0;
      end else begin
         pend_valid_r <= pend_valid_nx_s;
         pend_code_r  <= pend_code_nx_s;
      end
   end
`endif

   // Next-state logic: each non-idle state advances on a bit boundary.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      code_nx_s  = code_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid_s) begin
               state_nx_s = ST_START;
               code_nx_s  = req_code_s;
               idx_nx_s   = 2'd0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_nx_s = ST_DATA;
               idx_nx_s   = 2'd0;
            end else begin
               state_nx_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s && (idx_r == 2'd3)) begin
               state_nx_s = ST_GUARD;
            end else if (bit_end_s) begin
               idx_nx_s = idx_r + 2'd1;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         ST_GUARD: begin
            if (bit_end_s) begin
`ifdef PROTO_TX_PEND_EN
               // A request in this very cycle is taken directly when nothing is queued.
               if (pend_valid_r) begin
                  state_nx_s = ST_START;
                  code_nx_s  = pend_code_r;
                  idx_nx_s   = 2'd0;
               end else if (req_valid_s) begin
                  state_nx_s = ST_START;
                  code_nx_s  = req_code_s;
                  idx_nx_s   = 2'd0;
               end else begin
                  state_nx_s = ST_IDLE;
               end
`else
               state_nx_s = ST_IDLE;
`endif
            end else begin
               state_nx_s = ST_GUARD;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the outputs come straight from flops.
   always_comb begin
      data_nx_s = frame_bit(state_nx_s, idx_nx_s, code_nx_s);
      busy_nx_s = (state_nx_s != ST_IDLE);
      done_nx_s = (state_nx_s == ST_GUARD) && bit_end_nx_s;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= 2'd0;
         code_r  <= 4'd0;
         data_r  <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         idx_r   <= idx_nx_s;
         code_r  <= code_nx_s;
         data_r  <= data_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   assign data = data_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_protocolo_tx.sv
// Directed bench for protocolo_tx with BIT_CYCLES=1 and BIT_CYCLES=3 instances
// plus a falling-edge loopback receiver; expectations follow PROTO_TX_PEND_EN.
module tb_protocolo_tx;

   localparam logic [3:0] K_ON  = 4'b1001;
   localparam logic [3:0] K_OFF = 4'b1010;

   logic clk;
   logic rst;
   logic key_on1, key_off1, data1, busy1, done1;
   logic key_on3, key_off3, data3, busy3, done3;

   int tests = 0;
   int fails = 0;

   // Loopback receiver state
   logic       rx_act;
   logic [2:0] rx_cnt;
   logic [3:0] rx_sh;
   logic       rx_s;

   protocolo_tx #(.BIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .key_on(key_on1), .key_off(key_off1),
      .data(data1), .busy(busy1), .done(done1)
   );

   protocolo_tx #(.BIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .key_on(key_on3), .key_off(key_off3),
      .data(data3), .busy(busy3), .done(done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver sampling the BIT_CYCLES=1 line on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rx_act <= 1'b0;
         rx_cnt <= 3'd0;
         rx_sh  <= 4'd0;
         rx_s   <= 1'b0;
      end else if (!rx_act) begin
         if (data1 == 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 3'd0;
         end
      end else if (rx_cnt < 3'd4) begin
         rx_sh[rx_cnt[1:0]] <= data1;
         rx_cnt <= rx_cnt + 3'd1;
      end else begin
         rx_act <= 1'b0;
         if (data1 == 1'b1) begin
            if (rx_sh == K_ON) rx_s <= 1'b1;
            else if (rx_sh == K_OFF) rx_s <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Sends one request on the BIT_CYCLES=1 instance and checks the whole frame.
   task automatic send_bc1(input string tag, input logic on, input logic off,
                           input logic [3:0] code);
      logic [5:0] f;
      f = {1'b1, code, 1'b0};
      chk({tag, " pre data"}, data1, 1'b1);
      key_on1  = on;
      key_off1 = off;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin
            key_on1  = 1'b0;
            key_off1 = 1'b0;
         end
         chk($sformatf("%s data[%0d]", tag, i), data1, f[i]);
         chk($sformatf("%s busy[%0d]", tag, i), busy1, 1'b1);
         chk($sformatf("%s done[%0d]", tag, i), done1, (i == 5) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk({tag, " post data"}, data1, 1'b1);
      chk({tag, " post busy"}, busy1, 1'b0);
      chk({tag, " post done"}, done1, 1'b0);
   endtask

   initial begin
      logic [5:0] f;
      rst = 1'b1;
      key_on1 = 1'b0; key_off1 = 1'b0;
      key_on3 = 1'b0; key_off3 = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst data1", data1, 1'b1);
      chk("rst busy1", busy1, 1'b0);
      chk("rst done1", done1, 1'b0);
      chk("rst data3", data3, 1'b1);
      chk("rst busy3", busy3, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle busy1", busy1, 1'b0);
      chk("idle data1", data1, 1'b1);

      // BIT_CYCLES=1 key_on frame: 1,0,1,0,0,1,1
      send_bc1("on1", 1'b1, 1'b0, K_ON);

      // BIT_CYCLES=3 key_off frame: 0,0,1,0,1,1 each held 3 cycles
      f = {1'b1, K_OFF, 1'b0};
      chk("off3 pre data", data3, 1'b1);
      key_off3 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 0) key_off3 = 1'b0;
         chk($sformatf("off3 data[%0d]", i), data3, f[i / 3]);
         chk($sformatf("off3 busy[%0d]", i), busy3, 1'b1);
         chk($sformatf("off3 done[%0d]", i), done3, (i == 17) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk("off3 post busy", busy3, 1'b0);
      chk("off3 post data", data3, 1'b1);

      // Both keys high: no frame
      key_on1 = 1'b1; key_off1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("both data[%0d]", i), data1, 1'b1);
         chk($sformatf("both busy[%0d]", i), busy1, 1'b0);
      end
      key_on1 = 1'b0; key_off1 = 1'b0;
      @(negedge clk);
      chk("both after busy", busy1, 1'b0);

      // Reset during DATA(2), then a clean frame
      key_on1 = 1'b1;
      @(negedge clk);
      key_on1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort d2 data", data1, 1'b0);
      chk("abort d2 busy", busy1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort data", data1, 1'b1);
      chk("abort busy", busy1, 1'b0);
      chk("abort done", done1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("abort quiet done[%0d]", i), done1, 1'b0);
         chk($sformatf("abort quiet busy[%0d]", i), busy1, 1'b0);
      end
      send_bc1("on after abort", 1'b1, 1'b0, K_ON);

      // Reset wins over a request in the same cycle
      rst = 1'b1; key_on1 = 1'b1;
      @(negedge clk);
      chk("rst prio busy", busy1, 1'b0);
      chk("rst prio data", data1, 1'b1);
      rst = 1'b0; key_on1 = 1'b0;
      @(negedge clk);
      chk("rst prio after busy", busy1, 1'b0);

      // key_off pulsed during a key_on frame
      f = {1'b1, K_ON, 1'b0};
      key_on1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) key_on1 = 1'b0;
         if (i == 1) key_off1 = 1'b1;
         if (i == 2) key_off1 = 1'b0;
         chk($sformatf("pend f1 data[%0d]", i), data1, f[i]);
         chk($sformatf("pend f1 busy[%0d]", i), busy1, 1'b1);
         chk($sformatf("pend f1 done[%0d]", i), done1, (i == 5) ? 1'b1 : 1'b0);
      end
`ifdef PROTO_TX_PEND_EN
      f = {1'b1, K_OFF, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("pend f2 data[%0d]", i), data1, f[i]);
         chk($sformatf("pend f2 busy[%0d]", i), busy1, 1'b1);
         chk($sformatf("pend f2 done[%0d]", i), done1, (i == 5) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk("pend end busy", busy1, 1'b0);
`else
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("nopend data[%0d]", i), data1, 1'b1);
         chk($sformatf("nopend busy[%0d]", i), busy1, 1'b0);
         chk($sformatf("nopend done[%0d]", i), done1, 1'b0);
      end
`endif

      // Loopback receiver: S follows the decoded code
      send_bc1("lb off0", 1'b0, 1'b1, K_OFF);
      chk("lb S after off0", rx_s, 1'b0);
      send_bc1("lb on", 1'b1, 1'b0, K_ON);
      chk("lb S after on", rx_s, 1'b1);
      send_bc1("lb off", 1'b0, 1'b1, K_OFF);
      chk("lb S after off", rx_s, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
